// File: rtl/wb_regfile.sv
// Write-back register file: per-thread integer registers, PC bank, one shared write port
// with ALU priority and an in-order pending queue for colliding LSU load results.
module wb_regfile #(
   parameter int                  XLEN       = 32,
   parameter int                  ADDR_LEN   = 32,
   parameter int                  THREADS    = 4,
   parameter int                  PEND_DEPTH = 2,
   parameter logic [ADDR_LEN-1:0] RESET_PC   = '0
) (
   input  logic                               clk,
   input  logic                               rst,
   output logic                               init_done,
   output logic                               state_dbg,
   input  logic [$clog2(THREADS)-1:0]         rd_thread_id,
   input  logic [4:0]                         rs1_addr,
   input  logic [4:0]                         rs2_addr,
   output logic [XLEN-1:0]                    rs1_data,
   output logic [XLEN-1:0]                    rs2_data,
   output logic                               rs1_busy,
   output logic                               rs2_busy,
   input  logic                               alu_wb_en,
   input  logic [$clog2(THREADS)-1:0]         alu_wb_thread,
   input  logic [4:0]                         alu_wb_addr,
   input  logic [XLEN-1:0]                    alu_wb_data,
   input  logic                               lsu_wb_valid,
   output logic                               lsu_wb_ready,
   input  logic [$clog2(THREADS)-1:0]         lsu_wb_thread,
   input  logic [4:0]                         lsu_wb_addr,
   input  logic [XLEN-1:0]                    lsu_wb_data,
   input  logic                               pc_we,
   input  logic [$clog2(THREADS)-1:0]         pc_thread,
   input  logic [ADDR_LEN-3:0]                pc_next,
   output logic [THREADS*(ADDR_LEN-2)-1:0]    pc_out
);

   localparam int TW  = $clog2(THREADS);
   localparam int QPW = $clog2(PEND_DEPTH);
   localparam int QCW = QPW + 1;
   localparam int PCW = ADDR_LEN - 2;

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t          state, state_next;
   logic [4:0]      clr_idx;
   logic            run;

   logic [XLEN-1:0] regs [THREADS][32];
   logic [PCW-1:0]  pc_q [THREADS];

   logic [TW-1:0]   q_thread [PEND_DEPTH];
   logic [4:0]      q_addr   [PEND_DEPTH];
   logic [XLEN-1:0] q_data   [PEND_DEPTH];
   logic [QPW-1:0]  q_head, q_tail;
   logic [QCW-1:0]  q_count;
   logic            q_empty, q_full, q_push, q_pop;

   logic            lsu_acc;
   logic            wr_en, wr_commit;
   logic [TW-1:0]   wr_thread;
   logic [4:0]      wr_addr;
   logic [XLEN-1:0] wr_data;

   // LSU handshake: ready = RUN and queue not full; a transfer happens when valid & ready.
   // The LSU keeps valid and payload stable until the transfer cycle.

   always_ff @(posedge clk) begin
      if (rst) state <= S_INIT;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_INIT:  if (clr_idx == 5'd31) state_next = S_RUN;
         S_RUN:   state_next = S_RUN;
         default: state_next = S_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)                  clr_idx <= '0;
      else if (state == S_INIT) clr_idx <= clr_idx + 5'd1;
   end

   // rst gates the run qualifier so nothing commits in the reset cycle itself
   assign run       = (state == S_RUN) && !rst;
   assign init_done = run;
   assign state_dbg = (state == S_RUN);

   assign q_empty = (q_count == '0);
   assign q_full  = (q_count == QCW'(PEND_DEPTH));

   always_comb begin
      lsu_wb_ready = run && !q_full;
      lsu_acc      = lsu_wb_valid && lsu_wb_ready;
      wr_en        = 1'b0;
      wr_thread    = alu_wb_thread;
      wr_addr      = alu_wb_addr;
      wr_data      = alu_wb_data;
      q_pop        = 1'b0;
      q_push       = 1'b0;
      if (run) begin
         if (alu_wb_en) begin
            wr_en = 1'b1;
         end else if (!q_empty) begin
            wr_en     = 1'b1;
            wr_thread = q_thread[q_head];
            wr_addr   = q_addr[q_head];
            wr_data   = q_data[q_head];
            q_pop     = 1'b1;
         end else if (lsu_acc) begin
            wr_en     = 1'b1;
            wr_thread = lsu_wb_thread;
            wr_addr   = lsu_wb_addr;
            wr_data   = lsu_wb_data;
         end
         // queue whenever the port is taken by someone older or by the ALU; x0 is never queued
         q_push = lsu_acc && (lsu_wb_addr != 5'd0) && (alu_wb_en || !q_empty);
      end
   end

   assign wr_commit = wr_en && (wr_addr != 5'd0);

   always_ff @(posedge clk) begin
      if (state == S_INIT) begin
         for (int t = 0; t < THREADS; t++) regs[t][clr_idx] <= '0;
      end else if (wr_commit) begin
         regs[wr_thread][wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_head  <= '0;
         q_tail  <= '0;
         q_count <= '0;
      end else begin
         if (q_push) begin
            q_thread[q_tail] <= lsu_wb_thread;
            q_addr[q_tail]   <= lsu_wb_addr;
            q_data[q_tail]   <= lsu_wb_data;
            q_tail           <= q_tail + 1'b1;
         end
         if (q_pop) q_head <= q_head + 1'b1;
         if (q_push && !q_pop)      q_count <= q_count + 1'b1;
         else if (!q_push && q_pop) q_count <= q_count - 1'b1;
      end
   end

   always_comb begin
      rs1_data = '0;
      rs2_data = '0;
      if (rs1_addr != 5'd0) begin
         if (wr_commit && wr_thread == rd_thread_id && wr_addr == rs1_addr) rs1_data = wr_data;
         else rs1_data = regs[rd_thread_id][rs1_addr];
      end
      if (rs2_addr != 5'd0) begin
         if (wr_commit && wr_thread == rd_thread_id && wr_addr == rs2_addr) rs2_data = wr_data;
         else rs2_data = regs[rd_thread_id][rs2_addr];
      end
   end

   // busy looks at the queue as it stands before this cycle's pop
   always_comb begin
      rs1_busy = 1'b0;
      rs2_busy = 1'b0;
      for (int i = 0; i < PEND_DEPTH; i++) begin
         logic [QPW-1:0] off;
         off = QPW'(i) - q_head;
         if ({1'b0, off} < q_count && q_thread[i] == rd_thread_id) begin
            if (q_addr[i] == rs1_addr && rs1_addr != 5'd0) rs1_busy = 1'b1;
            if (q_addr[i] == rs2_addr && rs2_addr != 5'd0) rs2_busy = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int t = 0; t < THREADS; t++) pc_q[t] <= RESET_PC[ADDR_LEN-1:2];
      end else if (run && pc_we) begin
         pc_q[pc_thread] <= pc_next;
      end
   end

   always_comb begin
      pc_out = '0;
      for (int t = 0; t < THREADS; t++) pc_out[t*PCW +: PCW] = pc_q[t];
   end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed vector table, hand sequences for PC and mid-op reset,
// and random traffic checked against a queue-based reference model.
module tb_wb_regfile;

   localparam int          PD   = 2;
   localparam logic [31:0] RPC  = 32'h0000_0080;
   localparam logic [29:0] RPCW = 30'h20;

   logic        clk = 1'b0;
   logic        rst;
   logic        init_done, state_dbg;
   logic [1:0]  rd_thread_id;
   logic [4:0]  rs1_addr, rs2_addr;
   logic [31:0] rs1_data, rs2_data;
   logic        rs1_busy, rs2_busy;
   logic        alu_wb_en;
   logic [1:0]  alu_wb_thread;
   logic [4:0]  alu_wb_addr;
   logic [31:0] alu_wb_data;
   logic        lsu_wb_valid, lsu_wb_ready;
   logic [1:0]  lsu_wb_thread;
   logic [4:0]  lsu_wb_addr;
   logic [31:0] lsu_wb_data;
   logic        pc_we;
   logic [1:0]  pc_thread;
   logic [29:0] pc_next;
   logic [119:0] pc_out;

   wb_regfile #(.XLEN(32), .ADDR_LEN(32), .THREADS(4), .PEND_DEPTH(PD), .RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst), .init_done(init_done), .state_dbg(state_dbg),
      .rd_thread_id(rd_thread_id), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .alu_wb_en(alu_wb_en), .alu_wb_thread(alu_wb_thread), .alu_wb_addr(alu_wb_addr),
      .alu_wb_data(alu_wb_data), .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_wb_ready),
      .lsu_wb_thread(lsu_wb_thread), .lsu_wb_addr(lsu_wb_addr), .lsu_wb_data(lsu_wb_data),
      .pc_we(pc_we), .pc_thread(pc_thread), .pc_next(pc_next), .pc_out(pc_out)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic [1:0]  rd_t;
      logic [4:0]  rs1, rs2;
      logic        alu_en;
      logic [1:0]  alu_t;
      logic [4:0]  alu_a;
      logic [31:0] alu_d;
      logic        lsu_v;
      logic [1:0]  lsu_t;
      logic [4:0]  lsu_a;
      logic [31:0] lsu_d;
      logic        pc_we;
      logic [1:0]  pc_t;
      logic [29:0] pc_n;
      logic        chk;
      logic [31:0] e_rs1, e_rs2;
      logic        e_b1, e_b2, e_rdy;
   } vec_t;

   typedef struct {
      logic [1:0]  thread;
      logic [4:0]  addr;
      logic [31:0] data;
   } pend_t;

   // reference model state
   logic [31:0] m_regs [4][32];
   logic [29:0] m_pc [4];
   pend_t       pend_q[$];
   logic        m_run;
   int          m_init;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_rd(input logic [1:0] t, input logic [4:0] a, input logic w_en,
                                        input logic [1:0] w_t, input logic [4:0] w_a,
                                        input logic [31:0] w_d);
      if (a == 5'd0) return 32'd0;
      if (w_en && w_a == a && w_t == t) return w_d;
      return m_regs[t][a];
   endfunction

   function automatic vec_t mk(input logic [1:0] rd_t, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic alu_en, input logic [1:0] alu_t, input logic [4:0] alu_a,
                               input logic [31:0] alu_d, input logic lsu_v, input logic [1:0] lsu_t,
                               input logic [4:0] lsu_a, input logic [31:0] lsu_d,
                               input logic [31:0] e_rs1, input logic [31:0] e_rs2,
                               input logic e_b1, input logic e_b2, input logic e_rdy);
      vec_t v;
      v.rd_t = rd_t; v.rs1 = rs1; v.rs2 = rs2;
      v.alu_en = alu_en; v.alu_t = alu_t; v.alu_a = alu_a; v.alu_d = alu_d;
      v.lsu_v = lsu_v; v.lsu_t = lsu_t; v.lsu_a = lsu_a; v.lsu_d = lsu_d;
      v.pc_we = 1'b0; v.pc_t = 2'd0; v.pc_n = '0;
      v.chk = 1'b1; v.e_rs1 = e_rs1; v.e_rs2 = e_rs2; v.e_b1 = e_b1; v.e_b2 = e_b2; v.e_rdy = e_rdy;
      return v;
   endfunction

   function automatic vec_t idle(input logic [1:0] rd_t, input logic [4:0] rs1, input logic [4:0] rs2);
      vec_t v;
      v = mk(rd_t, rs1, rs2, 1'b0, 2'd0, 5'd0, 32'd0, 1'b0, 2'd0, 5'd0, 32'd0, 0, 0, 0, 0, 0);
      v.chk = 1'b0;
      return v;
   endfunction

   // driver + model step: drive, compare at negedge, advance model, return at posedge+1
   task automatic do_cycle(input vec_t v, output logic acc);
      logic        e_rdy, w_en, pop, push, b1, b2;
      logic [1:0]  w_t;
      logic [4:0]  w_a;
      logic [31:0] w_d, e1, e2;
      rd_thread_id = v.rd_t; rs1_addr = v.rs1; rs2_addr = v.rs2;
      alu_wb_en = v.alu_en; alu_wb_thread = v.alu_t; alu_wb_addr = v.alu_a; alu_wb_data = v.alu_d;
      lsu_wb_valid = v.lsu_v; lsu_wb_thread = v.lsu_t; lsu_wb_addr = v.lsu_a; lsu_wb_data = v.lsu_d;
      pc_we = v.pc_we; pc_thread = v.pc_t; pc_next = v.pc_n;
      @(negedge clk);
      e_rdy = m_run && (pend_q.size() < PD);
      acc = v.lsu_v && e_rdy;
      w_en = 1'b0; w_t = '0; w_a = '0; w_d = '0; pop = 1'b0; push = 1'b0;
      if (m_run) begin
         if (v.alu_en) begin
            w_en = 1'b1; w_t = v.alu_t; w_a = v.alu_a; w_d = v.alu_d;
         end else if (pend_q.size() != 0) begin
            w_en = 1'b1; w_t = pend_q[0].thread; w_a = pend_q[0].addr; w_d = pend_q[0].data; pop = 1'b1;
         end else if (acc) begin
            w_en = 1'b1; w_t = v.lsu_t; w_a = v.lsu_a; w_d = v.lsu_d;
         end
         push = acc && (v.lsu_a != 5'd0) && (v.alu_en || pend_q.size() != 0);
      end
      b1 = 1'b0; b2 = 1'b0;
      foreach (pend_q[i]) begin
         if (pend_q[i].thread == v.rd_t && pend_q[i].addr == v.rs1 && v.rs1 != 5'd0) b1 = 1'b1;
         if (pend_q[i].thread == v.rd_t && pend_q[i].addr == v.rs2 && v.rs2 != 5'd0) b2 = 1'b1;
      end
      e1 = m_rd(v.rd_t, v.rs1, w_en, w_t, w_a, w_d);
      e2 = m_rd(v.rd_t, v.rs2, w_en, w_t, w_a, w_d);
      chk("init_done", init_done, m_run);
      chk("lsu_wb_ready", lsu_wb_ready, e_rdy);
      if (m_run) begin
         chk("rs1_data", rs1_data, e1);
         chk("rs2_data", rs2_data, e2);
         chk("rs1_busy", rs1_busy, b1);
         chk("rs2_busy", rs2_busy, b2);
      end
      for (int t = 0; t < 4; t++) chk($sformatf("pc_out[%0d]", t), pc_out[t*30 +: 30], m_pc[t]);
      if (v.chk) begin
         chk("tbl_rs1_data", rs1_data, v.e_rs1);
         chk("tbl_rs2_data", rs2_data, v.e_rs2);
         chk("tbl_rs1_busy", rs1_busy, v.e_b1);
         chk("tbl_rs2_busy", rs2_busy, v.e_b2);
         chk("tbl_ready", lsu_wb_ready, v.e_rdy);
      end
      if (w_en && w_a != 5'd0) m_regs[w_t][w_a] = w_d;
      if (pop) void'(pend_q.pop_front());
      if (push) pend_q.push_back('{thread: v.lsu_t, addr: v.lsu_a, data: v.lsu_d});
      if (m_run && v.pc_we) m_pc[v.pc_t] = v.pc_n;
      if (!m_run) begin
         m_init++;
         if (m_init == 32) begin
            m_run = 1'b1;
            for (int t = 0; t < 4; t++) for (int r = 0; r < 32; r++) m_regs[t][r] = '0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      alu_wb_en = 1'b0; lsu_wb_valid = 1'b0; pc_we = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      pend_q.delete();
      m_run = 1'b0;
      m_init = 0;
      for (int t = 0; t < 4; t++) m_pc[t] = RPCW;
   endtask

   task automatic init_phase();
      logic a;
      for (int i = 0; i < 33; i++) do_cycle(idle(2'(i), 5'(i), 5'(i + 1)), a);
   endtask

   vec_t        tbl [15];
   vec_t        v;
   logic        acc;
   logic        lsu_pend;
   logic [1:0]  h_t;
   logic [4:0]  h_a;
   logic [31:0] h_d;

   initial begin
      rst = 1'b0;
      rd_thread_id = '0; rs1_addr = '0; rs2_addr = '0;
      alu_wb_en = 1'b0; alu_wb_thread = '0; alu_wb_addr = '0; alu_wb_data = '0;
      lsu_wb_valid = 1'b0; lsu_wb_thread = '0; lsu_wb_addr = '0; lsu_wb_data = '0;
      pc_we = 1'b0; pc_thread = '0; pc_next = '0;
      m_run = 1'b0; m_init = 0;

      //         rd rs1 rs2 alu  t  a   data          lsu t  a  data   e_rs1         e_rs2  b1 b2 rdy
      tbl[0]  = mk(2, 5,  0,  1, 2, 5,  32'hDEADBEEF, 0,  0, 0, 0,     32'hDEADBEEF, 0,     0, 0, 1);
      tbl[1]  = mk(2, 5,  0,  0, 0, 0,  0,            0,  0, 0, 0,     32'hDEADBEEF, 0,     0, 0, 1);
      tbl[2]  = mk(1, 5,  5,  0, 0, 0,  0,            0,  0, 0, 0,     0,            0,     0, 0, 1);
      tbl[3]  = mk(0, 4,  3,  1, 0, 3,  1,            1,  0, 4, 2,     0,            1,     0, 0, 1);
      tbl[4]  = mk(0, 4,  3,  0, 0, 0,  0,            0,  0, 0, 0,     2,            1,     1, 0, 1);
      tbl[5]  = mk(0, 4,  3,  0, 0, 0,  0,            0,  0, 0, 0,     2,            1,     0, 0, 1);
      tbl[6]  = mk(1, 6,  7,  1, 1, 10, 32'h10A,      1,  1, 6, 6,     0,            0,     0, 0, 1);
      tbl[7]  = mk(1, 6,  7,  1, 1, 11, 32'h10B,      1,  1, 7, 7,     0,            0,     1, 0, 1);
      tbl[8]  = mk(1, 6,  7,  1, 1, 12, 32'h10C,      1,  1, 8, 8,     0,            0,     1, 1, 0);
      tbl[9]  = mk(1, 6,  7,  0, 0, 0,  0,            1,  1, 8, 8,     6,            0,     1, 1, 0);
      tbl[10] = mk(1, 7,  8,  0, 0, 0,  0,            1,  1, 8, 8,     7,            0,     1, 0, 1);
      tbl[11] = mk(1, 8,  6,  0, 0, 0,  0,            0,  0, 0, 0,     8,            6,     1, 0, 1);
      tbl[12] = mk(1, 10, 12, 0, 0, 0,  0,            0,  0, 0, 0,     32'h10A,      32'h10C, 0, 0, 1);
      tbl[13] = mk(0, 0,  0,  1, 0, 0,  5,            1,  0, 0, 7,     0,            0,     0, 0, 1);
      tbl[14] = mk(0, 9,  0,  0, 0, 0,  0,            1,  0, 9, 32'h99, 32'h99,      0,     0, 0, 1);

      do_reset();
      init_phase();

      for (int i = 0; i < 15; i++) do_cycle(tbl[i], acc);

      // PC update visible one cycle later, other threads untouched
      v = idle(0, 0, 0);
      v.pc_we = 1'b1; v.pc_t = 2'd3; v.pc_n = 30'h100;
      do_cycle(v, acc);
      chk("pc_t3_after_we", pc_out[90 +: 30], 30'h100);
      chk("pc_t0_unchanged", pc_out[0 +: 30], RPCW);

      // random traffic against the model; LSU holds its payload until accepted
      lsu_pend = 1'b0; h_t = '0; h_a = '0; h_d = '0;
      for (int n = 0; n < 400; n++) begin
         v = idle(2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         v.alu_en = 1'($urandom_range(0, 1));
         v.alu_t = 2'($urandom_range(0, 3));
         v.alu_a = 5'($urandom_range(0, 7));
         v.alu_d = $urandom;
         v.pc_we = ($urandom_range(0, 4) == 0);
         v.pc_t = 2'($urandom_range(0, 3));
         v.pc_n = 30'($urandom);
         if (!lsu_pend && $urandom_range(0, 9) < 6) begin
            lsu_pend = 1'b1;
            h_t = 2'($urandom_range(0, 3));
            h_a = 5'($urandom_range(0, 7));
            h_d = $urandom;
         end
         v.lsu_v = lsu_pend; v.lsu_t = h_t; v.lsu_a = h_a; v.lsu_d = h_d;
         do_cycle(v, acc);
         if (acc) lsu_pend = 1'b0;
      end
      for (int k = 0; k < 10 && lsu_pend; k++) begin
         v = idle(0, 1, 2);
         v.lsu_v = 1'b1; v.lsu_t = h_t; v.lsu_a = h_a; v.lsu_d = h_d;
         do_cycle(v, acc);
         if (acc) lsu_pend = 1'b0;
      end
      chk("lsu_drain_bounded", lsu_pend, 1'b0);
      for (int k = 0; k < 3; k++) do_cycle(idle(3, 20, 21), acc);

      // fill the queue, then reset mid-operation
      do_cycle(mk(3, 20, 21, 1, 2, 1, 32'h11, 1, 3, 20, 32'h2020, 0, 0, 0, 0, 1), acc);
      do_cycle(mk(3, 20, 21, 1, 2, 1, 32'h12, 1, 3, 21, 32'h2121, 0, 0, 1, 0, 1), acc);
      lsu_wb_valid = 1'b0; alu_wb_en = 1'b0;
      chk("queue_full_ready", lsu_wb_ready, 1'b0);
      do_reset();
      init_phase();
      chk("pc_t3_after_reset", pc_out[90 +: 30], RPCW);
      do_cycle(mk(3, 20, 21, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), acc);
      do_cycle(mk(3, 20, 21, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), acc);
      do_cycle(mk(2, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), acc);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
